seq_d_arbiter: RTL and testbench
================================

// Module: seq_d_arbiter
// PURPOSE
// - Shares one Seq_D-style two-flop recogniser datapath among N_CH serial requesters.
// - Each channel's recogniser state (q1,q2) lives in a per-channel state file.
// - A round-robin arbiter accepts at most one bit per cycle, advances that channel's
//   state and returns the recogniser output Y one cycle later.
// - Sits between the serial bit sources and the downstream result consumer.
// PARAMETERS
// - N_CH  default 4  number of requesting channels (2..16)
// - CW    derived    localparam = $clog2(N_CH), width of channel index
// PORTS
// - clk          in   1     rising-edge clock
// - reset        in   1     reset, synchronous, active-low
// - req_valid_i  in   N_CH  per-channel bit available
// - req_bit_i    in   N_CH  per-channel serial bit X
// - req_ready_o  out  N_CH  one-hot accept, combinational; at most one bit set
// - clr_i        in   N_CH  per-channel synchronous state clear
// - out_valid_o  out  1     result valid (registered)
// - out_ready_i  in   1     consumer accepts result
// - out_chan_o   out  CW    channel index of the result
// - out_y_o      out  1     recogniser output Y after the update
// BEHAVIOUR
// - Reset (reset==0 at posedge):
//   - all channel states = (q1,q2) = (0,0)
//   - rr pointer = 0
//   - out_valid_o = 0, out_chan_o = 0, out_y_o = 0
//   - req_ready_o = 0 in the same cycle
// - Next-state per channel, identical to the shared datapath:
//   - q1' = X & ~q1
//   - q2' = ~q2 | q1
//   - Y   = q2' | ~q1'  (taken from the post-update state)
// - Stall: hold = out_valid_o & ~out_ready_i. While hold, req_ready_o = 0 and the
//   output registers keep their values.
// - Arbitration:
//   - eligible[c] = req_valid_i[c] & ~clr_i[c] & ~hold
//   - winner = first eligible index at or after the rr pointer, wrapping N_CH-1 -> 0
//   - req_ready_o = onehot(winner), or 0 when nothing is eligible
// - Transfer at posedge when req_valid_i[w] & req_ready_o[w]:
//   - state[w] <= next-state(state[w], req_bit_i[w])
//   - out_valid_o <= 1, out_chan_o <= w, out_y_o <= Y
//   - rr pointer <= (w+1) mod N_CH
//   - latency is one cycle from accept to out_valid_o
// - No transfer, no hold: out_valid_o <= 0; out_chan_o and out_y_o hold; pointer unchanged.
// - Clear:
//   - clr_i[c] sets state[c] <= (0,0) at posedge
//   - a cleared channel is never granted in that cycle, so clear beats request
//   - clearing a channel whose result is in the output register does not change
//     that result
// - Back-to-back operation: with out_ready_i = 1, one result per cycle, full throughput.
// - Requesters hold req_valid_i and req_bit_i stable until they see req_ready_o; the
//   arbiter tolerates withdrawal without a grant.
// STRUCTURE
// - Shared package seq_d_pkg:
//   - typedef seq_state_t {q1,q2}
//   - constant SEQ_RESET_STATE = 2'b00
//   - function seq_next(state, x) returning next state and Y
// - Sub-module seq_d_next: combinational next-state/Y function, one instance on the
//   muxed winner state.
// - Top holds the state file, the round-robin arbiter, the output register and the
//   stall logic.
// TESTING
// - Reset then ch0 bits 1,0,1 with all others idle -> ch0 Y = 1,1,0; out_chan = 0 each;
//   one-cycle latency.
// - All 4 channels valid continuously, ptr=0 -> grants ch0,1,2,3,0,...; one out_valid
//   per cycle.
// - out_ready_i=0 while out_valid=1 for 3 cycles -> req_ready=0, outputs frozen;
//   on release the stored result is consumed once and granting resumes.
// - clr_i[2]=1 with req_valid_i[2]=1 -> ch2 not granted that cycle, ch3 granted if valid;
//   ch2 next bit 1 -> Y=1 (from state 00).
// - ch1 at state 01, then reset=0 for 1 cycle -> out_valid=0, ptr=0; ch1 bit 1 -> Y=1
//   (not 0).
// - Only ch3 valid, ptr=3 -> ch3 granted, ptr wraps to 0; then ch0,ch3 valid -> ch0 first.

Source files
------------

// File: rtl/seq_d_pkg.sv
// Shared types and next-state function for the Seq_D two-flop recogniser.
package seq_d_pkg;

  typedef struct packed {
    logic q1;
    logic q2;
  } seq_state_t;

  typedef struct packed {
    seq_state_t nxt;
    logic       y;
  } seq_result_t;

  localparam seq_state_t SEQ_RESET_STATE = 2'b00;

  // Y is taken from the post-update state.
  function automatic seq_result_t seq_next(
    input seq_state_t s,
    input logic       x
  );
    seq_result_t r;
    r.nxt.q1 = x & ~s.q1;
    r.nxt.q2 = ~s.q2 | s.q1;
    r.y      = r.nxt.q2 | ~r.nxt.q1;
    return r;
  endfunction

endpackage

// File: rtl/seq_d_next.sv
// Combinational Seq_D next-state and Y for the shared datapath.
module seq_d_next
  import seq_d_pkg::*;
(
  input  seq_state_t state_i,
  input  logic       x_i,
  output seq_state_t state_o,
  output logic       y_o
);

  seq_result_t r;

  assign r       = seq_next(state_i, x_i);
  assign state_o = r.nxt;
  assign y_o     = r.y;

endmodule

// File: rtl/seq_d_arbiter.sv
// Round-robin sharing of one Seq_D recogniser among N_CH serial channels,
// with a per-channel state file and a single registered result slot.
module seq_d_arbiter
  import seq_d_pkg::*;
#(
  parameter int N_CH = 4,
  localparam int CW  = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] req_valid_i,
  input  logic [N_CH-1:0] req_bit_i,
  output logic [N_CH-1:0] req_ready_o,
  input  logic [N_CH-1:0] clr_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [CW-1:0]   out_chan_o,
  output logic            out_y_o
);

  seq_state_t      st [N_CH];
  seq_state_t      cur;
  seq_state_t      nxt;
  logic            y_n;
  logic [CW-1:0]   ptr;
  logic [CW-1:0]   win;
  logic [CW-1:0]   ptr_nxt;
  logic [N_CH-1:0] elig;
  logic            hold;
  logic            found;
  int              idx;

  assign hold = out_valid_o & ~out_ready_i;

  // Clear beats request; nothing is granted in a reset cycle.
  assign elig = req_valid_i & ~clr_i
              & {N_CH{~hold & reset}};

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = (int'(ptr) + k) % N_CH;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = CW'(idx);
      end
    end
  end

  assign req_ready_o = found
    ? ({{(N_CH-1){1'b0}}, 1'b1} << win)
    : '0;

  assign cur = st[win];

  seq_d_next u_next (
    .state_i (cur),
    .x_i     (req_bit_i[win]),
    .state_o (nxt),
    .y_o     (y_n)
  );

  assign ptr_nxt = (win == CW'(N_CH-1))
    ? '0 : win + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < N_CH; c++)
        st[c] <= SEQ_RESET_STATE;
      ptr         <= '0;
      out_valid_o <= 1'b0;
      out_chan_o  <= '0;
      out_y_o     <= 1'b0;
    end else begin
      for (int c = 0; c < N_CH; c++)
        if (clr_i[c]) st[c] <= SEQ_RESET_STATE;
      if (found) st[win] <= nxt;
      if (!hold) begin
        out_valid_o <= found;
        if (found) begin
          out_chan_o <= win;
          out_y_o    <= y_n;
          ptr        <= ptr_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_d_arbiter.sv
// Self-checking bench for seq_d_arbiter: vector table plus corner sequences,
// results matched through an expected-result queue.
module tb_seq_d_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req_valid_i = '0;
  logic [3:0] req_bit_i = '0;
  logic [3:0] clr_i = '0;
  logic [3:0] req_ready_o;
  logic       out_valid_o;
  logic       out_ready_i = 1'b1;
  logic [1:0] out_chan_o;
  logic       out_y_o;

  seq_d_arbiter #(.N_CH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid_i),
    .req_bit_i   (req_bit_i),
    .req_ready_o (req_ready_o),
    .clr_i       (clr_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_chan_o  (out_chan_o),
    .out_y_o     (out_y_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] chan;
    logic       y;
  } res_t;

  typedef struct packed {
    logic [3:0] v;
    logic [3:0] b;
    logic [3:0] c;
    logic       ordy;
    logic [3:0] rdy;
    logic       y;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  res_t sb[$];
  logic exp_ov = 1'b0;
  vec_t tbl[$];

  function automatic logic [1:0] oh2i(input logic [3:0] oh);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic       rst,
                     input logic [3:0] v,
                     input logic [3:0] b,
                     input logic [3:0] c,
                     input logic       ordy,
                     input logic [3:0] erdy,
                     input logic       ey);
    res_t r;
    @(negedge clk);
    reset       = rst;
    req_valid_i = v;
    req_bit_i   = b;
    clr_i       = c;
    out_ready_i = ordy;
    #1;
    chk("req_ready", 32'(req_ready_o), 32'(erdy));
    chk("out_valid", 32'(out_valid_o), 32'(exp_ov));
    if (!rst) begin
      sb.delete();
    end else if (out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_extra actual=valid required=none");
      end else begin
        r = sb.pop_front();
        chk("out_chan", 32'(out_chan_o), 32'(r.chan));
        chk("out_y", 32'(out_y_o), 32'(r.y));
      end
    end
    if (rst && erdy != 4'b0)
      sb.push_back({oh2i(erdy), ey});
    exp_ov = rst && ((erdy != 4'b0) || (exp_ov && !ordy));
  endtask

  initial begin
    // ch0 bits 1,0,1 alone: Y = 1,1,0
    tbl.push_back({4'h1, 4'h1, 4'h0, 1'b1, 4'h1, 1'b1});
    tbl.push_back({4'h1, 4'h0, 4'h0, 1'b1, 4'h1, 1'b1});
    tbl.push_back({4'h1, 4'h1, 4'h0, 1'b1, 4'h1, 1'b0});
    tbl.push_back({4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0});
    // reset row marked by c=F is handled below
    tbl.push_back({4'hF, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0});
    // all channels valid: 0,1,2,3,0
    tbl.push_back({4'hF, 4'hF, 4'h0, 1'b1, 4'h1, 1'b1});
    tbl.push_back({4'hF, 4'hF, 4'h0, 1'b1, 4'h2, 1'b1});
    tbl.push_back({4'hF, 4'hF, 4'h0, 1'b1, 4'h4, 1'b1});
    tbl.push_back({4'hF, 4'hF, 4'h0, 1'b1, 4'h8, 1'b1});
    tbl.push_back({4'hF, 4'hF, 4'h0, 1'b1, 4'h1, 1'b1});

    reset = 1'b0;
    req_valid_i = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready_o), 32'h0);
    chk("rst_valid", 32'(out_valid_o), 32'h0);
    chk("rst_chan", 32'(out_chan_o), 32'h0);
    chk("rst_y", 32'(out_y_o), 32'h0);

    foreach (tbl[i]) begin
      if (tbl[i].c == 4'hF)
        cyc(1'b0, tbl[i].v, tbl[i].b, 4'h0,
            tbl[i].ordy, tbl[i].rdy, tbl[i].y);
      else
        cyc(1'b1, tbl[i].v, tbl[i].b, tbl[i].c,
            tbl[i].ordy, tbl[i].rdy, tbl[i].y);
    end

    // stall three cycles: no grants, outputs frozen
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
      chk("stall_chan", 32'(out_chan_o), 32'h0);
      chk("stall_y", 32'(out_y_o), 32'h1);
    end
    // release: stored result consumed once, ch1 granted (11,x0 -> Y=1)
    cyc(1'b1, 4'hF, 4'h0, 4'h0, 1'b1, 4'h2, 1'b1);

    // ch2 to state 01, then clear it while ch3 is granted
    cyc(1'b1, 4'h4, 4'h0, 4'h0, 1'b1, 4'h4, 1'b1);
    cyc(1'b1, 4'hC, 4'hF, 4'h4, 1'b1, 4'h8, 1'b1);
    // ch2 from 00 with bit 1 -> Y=1 (would be 0 from 01)
    cyc(1'b1, 4'h4, 4'h4, 4'h0, 1'b1, 4'h4, 1'b1);
    cyc(1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0);

    // ch1 sits at 01; one reset cycle returns it to 00, ptr to 0
    cyc(1'b0, 4'h2, 4'h2, 4'h0, 1'b1, 4'h0, 1'b0);
    cyc(1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0);
    chk("post_rst_chan", 32'(out_chan_o), 32'h0);
    chk("post_rst_y", 32'(out_y_o), 32'h0);
    cyc(1'b1, 4'h3, 4'h3, 4'h0, 1'b1, 4'h1, 1'b1);
    cyc(1'b1, 4'h2, 4'h2, 4'h0, 1'b1, 4'h2, 1'b1);

    // ptr wrap: ch2, then ch3 alone at ptr=3, then ch0 before ch3
    cyc(1'b1, 4'h4, 4'h0, 4'h0, 1'b1, 4'h4, 1'b1);
    cyc(1'b1, 4'h8, 4'h8, 4'h0, 1'b1, 4'h8, 1'b1);
    cyc(1'b1, 4'h9, 4'h0, 4'h0, 1'b1, 4'h1, 1'b1);
    cyc(1'b1, 4'h8, 4'h8, 4'h0, 1'b1, 4'h8, 1'b1);
    // ch0 at 01 with bit 1 -> Y=0
    cyc(1'b1, 4'h1, 4'h1, 4'h0, 1'b1, 4'h1, 1'b0);
    cyc(1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0);
    cyc(1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
